// File: rtl/mac_16_feeder_pkg.sv
// Shared constants and FSM state type for the MAC feeder.
package mac_16_feeder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAPS   = 16;
  localparam int unsigned WD_MAX = 64;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/mac_16_feeder_tap_window.sv
// TAPS x DATA_W shift register; tap 0 (LSBs) holds the newest sample.
module tap_window #(
  parameter int unsigned DATA_W = mac_16_feeder_pkg::DATA_W,
  parameter int unsigned TAPS   = mac_16_feeder_pkg::TAPS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic [DATA_W-1:0]        i_din,
  output logic [TAPS*DATA_W-1:0]   o_taps
);

  logic [TAPS*DATA_W-1:0] r_taps;

  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_taps <= '0;
    end else if (i_en) begin
      r_taps <= {r_taps[(TAPS-1)*DATA_W-1:0], i_din};
    end
  end

  assign o_taps = r_taps;

endmodule

// File: rtl/mac_16_feeder.sv
// Collects a sliding sample window, launches the MAC core on each fresh
// window, and hands its result downstream with a watchdog on the wait.
module mac_16_feeder #(
  parameter int unsigned DATA_W = mac_16_feeder_pkg::DATA_W,
  parameter int unsigned TAPS   = mac_16_feeder_pkg::TAPS,
  parameter int unsigned WD_MAX = mac_16_feeder_pkg::WD_MAX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     flush,
  output logic [TAPS*DATA_W-1:0]   taps,
  output logic                     mac_start,
  input  logic                     mac_busy,
  input  logic                     mac_valid,
  input  logic [DATA_W-1:0]        mac_result,
  output logic [DATA_W-1:0]        r_data,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [15:0]              res_cnt,
  output logic                     wd_err
);

  import mac_16_feeder_pkg::*;

  localparam int unsigned CNT_W = $clog2(TAPS + 1);
  localparam int unsigned WD_W  = $clog2(WD_MAX + 1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_fill_cnt;
  logic                r_fresh;
  logic [WD_W-1:0]     r_wd;
  logic [DATA_W-1:0]   r_result;
  logic [15:0]         r_res_cnt;
  logic                r_wd_err;

  logic w_full, w_go, w_take, w_expire, w_accept, w_clr;

  assign w_full = (r_fill_cnt == CNT_W'(TAPS));

  always_comb begin
    w_next    = r_state;
    s_ready   = 1'b0;
    mac_start = 1'b0;
    r_valid   = 1'b0;
    w_go      = 1'b0;
    w_take    = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      FILL: begin
        // Launch cycle refuses samples so the window stays exactly as issued.
        w_go    = w_full && r_fresh && !mac_busy && !flush;
        s_ready = !w_go;
        if (w_go) w_next = ISSUE;
      end
      ISSUE: begin
        mac_start = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (mac_valid) begin
          w_take = 1'b1;
          w_next = HOLD;
        end else if (r_wd == WD_W'(WD_MAX - 1)) begin
          w_expire = 1'b1;
          w_next   = FILL;
        end
      end
      HOLD: begin
        r_valid = 1'b1;
        if (r_ready) w_next = FILL;
      end
      default: w_next = FILL;
    endcase
    if (!reset) begin
      s_ready   = 1'b0;
      mac_start = 1'b0;
      r_valid   = 1'b0;
    end
  end

  assign w_clr    = (r_state == FILL) && flush;
  assign w_accept = s_valid && s_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= FILL;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fill_cnt <= '0;
      r_fresh    <= 1'b0;
      r_wd       <= '0;
      r_result   <= '0;
      r_res_cnt  <= '0;
      r_wd_err   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_fill_cnt <= '0;
        r_fresh    <= 1'b0;
      end else if (w_accept) begin
        if (!w_full) r_fill_cnt <= r_fill_cnt + CNT_W'(1);
        r_fresh <= 1'b1;
      end else if (r_state == ISSUE) begin
        r_fresh <= 1'b0;
      end
      if (r_state == ISSUE)     r_wd <= '0;
      else if (r_state == WAIT) r_wd <= r_wd + WD_W'(1);
      if (w_take)   r_result <= mac_result;
      if (w_expire) r_wd_err <= 1'b1;
      if (r_state == HOLD && r_ready) r_res_cnt <= r_res_cnt + 16'd1;
    end
  end

  tap_window #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_tap_window (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_accept),
    .i_din  (s_data),
    .o_taps (taps)
  );

  assign r_data  = r_result;
  assign res_cnt = r_res_cnt;
  assign wd_err  = r_wd_err;

endmodule

// File: tb/tb_mac_16_feeder.sv
// Directed bench for mac_16_feeder with a transaction-level reference model.
module tb_mac_16_feeder;

  localparam int unsigned DW = 32;
  localparam int unsigned NT = 16;

  logic              clk;
  logic              reset;
  logic [DW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic              flush;
  logic [NT*DW-1:0]  taps;
  logic              mac_start;
  logic              mac_busy;
  logic              mac_valid;
  logic [DW-1:0]     mac_result;
  logic [DW-1:0]     r_data;
  logic              r_valid;
  logic              r_ready;
  logic [15:0]       res_cnt;
  logic              wd_err;

  int checks   = 0;
  int failures = 0;

  mac_16_feeder #(
    .DATA_W (32),
    .TAPS   (16),
    .WD_MAX (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .flush      (flush),
    .taps       (taps),
    .mac_start  (mac_start),
    .mac_busy   (mac_busy),
    .mac_valid  (mac_valid),
    .mac_result (mac_result),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .res_cnt    (res_cnt),
    .wd_err     (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: window as an array, phases as independent flags.
  logic [DW-1:0] m_win [NT];
  int            m_cnt;
  bit            m_fresh, m_start, m_waiting, m_hold, m_wderr, m_live;
  int            m_wcyc;
  logic [DW-1:0] m_rdata;
  logic [15:0]   m_rescnt;

  function automatic bit m_idle();
    return !m_start && !m_waiting && !m_hold;
  endfunction

  function automatic bit m_launch();
    return m_idle() && (m_cnt == NT) && m_fresh && !mac_busy && !flush;
  endfunction

  initial m_live = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_live = 1'b1;
      for (int k = 0; k < NT; k++) m_win[k] = '0;
      m_cnt = 0; m_fresh = 0; m_start = 0; m_waiting = 0; m_hold = 0;
      m_wderr = 0; m_wcyc = 0; m_rdata = '0; m_rescnt = '0;
    end else if (m_live) begin
      if (m_start) begin
        m_start = 0; m_waiting = 1; m_wcyc = 0; m_fresh = 0;
      end else if (m_waiting) begin
        if (mac_valid) begin
          m_rdata = mac_result; m_hold = 1; m_waiting = 0;
        end else begin
          m_wcyc++;
          if (m_wcyc == 64) begin
            m_wderr = 1; m_waiting = 0;
          end
        end
      end else if (m_hold) begin
        if (r_ready) begin
          m_rescnt = m_rescnt + 16'd1; m_hold = 0;
        end
      end else if (flush) begin
        for (int k = 0; k < NT; k++) m_win[k] = '0;
        m_cnt = 0; m_fresh = 0;
      end else if (m_launch()) begin
        m_start = 1;
      end else if (s_valid) begin
        for (int k = NT - 1; k > 0; k--) m_win[k] = m_win[k-1];
        m_win[0] = s_data;
        if (m_cnt < NT) m_cnt++;
        m_fresh = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [NT*DW-1:0] exp_taps;
      for (int k = 0; k < NT; k++) exp_taps[k*DW +: DW] = m_win[k];
      chk("m_taps",      taps,      exp_taps);
      chk("m_s_ready",   s_ready,   reset && m_idle() && !m_launch());
      chk("m_mac_start", mac_start, reset && m_start);
      chk("m_r_valid",   r_valid,   reset && m_hold);
      chk("m_r_data",    r_data,    m_rdata);
      chk("m_res_cnt",   res_cnt,   m_rescnt);
      chk("m_wd_err",    wd_err,    m_wderr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] tap_of(input int unsigned k);
    return taps[k*DW +: DW];
  endfunction

  initial begin
    reset = 1'b0; s_data = '0; s_valid = 1'b0; flush = 1'b0;
    mac_busy = 1'b0; mac_valid = 1'b0; mac_result = '0; r_ready = 1'b0;
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_taps", taps, '0);
    chk("rst_res_cnt", res_cnt, 16'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_s_ready", s_ready, 1'b1);

    // Fill window with 1..16
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("fill_tap0", tap_of(0), 32'd16);
    chk("fill_tap15", tap_of(15), 32'd1);
    chk("fill_tap7", tap_of(7), 32'd9);
    chk("lat_start_1", mac_start, 1'b0);
    tick();
    chk("lat_start_2", mac_start, 1'b1);
    chk("issue_s_ready", s_ready, 1'b0);
    tick();
    chk("start_once", mac_start, 1'b0);

    // Result 0x1234 five cycles after start, consumer stalls 3 cycles
    repeat (3) tick();
    mac_valid = 1'b1; mac_result = 32'h1234;
    tick();
    mac_valid = 1'b0; mac_result = '0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_r_valid", r_valid, 1'b1);
      chk("hold_r_data", r_data, 32'h1234);
      chk("hold_res_cnt", res_cnt, 16'd0);
      chk("hold_s_ready", s_ready, 1'b0);
      if (i == 1) begin
        mac_valid = 1'b1; mac_result = 32'hDEAD;
      end
      tick();
      mac_valid = 1'b0;
    end
    chk("hold_ignore_mv", r_data, 32'h1234);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("res_cnt_1", res_cnt, 16'd1);
    chk("after_hold_r_valid", r_valid, 1'b0);
    chk("after_hold_s_ready", s_ready, 1'b1);

    // Sample 17 while MAC busy
    mac_busy = 1'b1;
    send(32'd17);
    chk("s17_tap0", tap_of(0), 32'd17);
    chk("s17_tap15", tap_of(15), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_no_start", mac_start, 1'b0);
    end
    mac_busy = 1'b0;
    tick();
    chk("busy_release_start", mac_start, 1'b1);
    tick();
    chk("busy_single_pulse", mac_start, 1'b0);
    mac_valid = 1'b1; mac_result = 32'hBEEF;
    tick();
    mac_valid = 1'b0;
    chk("fast_r_data", r_data, 32'hBEEF);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("res_cnt_2", res_cnt, 16'd2);
    mac_valid = 1'b1; mac_result = 32'hDEAD;
    tick();
    mac_valid = 1'b0;
    chk("fill_ignore_mv", r_data, 32'hBEEF);
    chk("fill_ignore_rv", r_valid, 1'b0);

    // Watchdog: no mac_valid
    send(32'd18);
    tick();
    chk("wd_start", mac_start, 1'b1);
    tick();
    repeat (63) tick();
    chk("wd_not_yet", wd_err, 1'b0);
    chk("wd_still_wait", s_ready, 1'b0);
    tick();
    chk("wd_err_set", wd_err, 1'b1);
    chk("wd_s_ready", s_ready, 1'b1);
    chk("wd_r_valid", r_valid, 1'b0);
    chk("wd_res_cnt", res_cnt, 16'd2);

    // Flush: clear, 10 samples, flush with a colliding sample
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h100 + DW'(i));
    chk("pre_flush_tap0", tap_of(0), 32'h109);
    flush = 1'b1; s_valid = 1'b1; s_data = 32'hAA;
    tick();
    flush = 1'b0; s_valid = 1'b0;
    chk("flush_taps", taps, '0);
    for (int i = 0; i < 15; i++) begin
      send(32'h200 + DW'(i));
      chk("refill_no_start", mac_start, 1'b0);
    end
    repeat (2) begin
      tick();
      chk("refill15_no_start", mac_start, 1'b0);
    end
    send(32'h20F);
    chk("refill_tap0", tap_of(0), 32'h20F);
    chk("refill_tap15", tap_of(15), 32'h200);
    tick();
    chk("refill_start", mac_start, 1'b1);

    // Reset mid-WAIT, then a stray mac_valid
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_wait_s_ready", s_ready, 1'b0);
    chk("rst_wait_wd_err", wd_err, 1'b0);
    reset = 1'b1;
    mac_valid = 1'b1; mac_result = 32'h5555;
    tick();
    mac_valid = 1'b0;
    tick();
    chk("rst_wait_r_valid", r_valid, 1'b0);
    chk("rst_wait_res_cnt", res_cnt, 16'd0);
    chk("rst_wait_r_data", r_data, 32'd0);
    chk("rst_wait_fill", s_ready, 1'b1);
    chk("rst_wait_taps", taps, '0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
